key_event_fifo: RTL and testbench
=================================

Name: key_event_fifo

Overview:
- Parametrised successor to the single ASCII holding register between the PS/2 keyboard decoder and the PicoBlaze.
- Buffers DEPTH key codes of DATA_W bits and drives the PicoBlaze interrupt while codes are pending.
- Pops one code per interrupt_ack, and holds the interrupt off for a programmable gap so the CPU can re-enable interrupts.
- Adds sticky overflow reporting and an occupancy count.

Parameters:
DATA_W, 8, key code width
DEPTH, 8, FIFO entries; power of two, minimum 2
IRQ_GAP, 4, cycles interrupt stays low after each ack (minimum 1)
REPEAT_HOLD, 1000000, duplicate-suppression window in cycles (used only with KEY_DUP_FILTER_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
key_valid  in  1  one-cycle strobe: key_code valid
key_code  in  DATA_W  code from keyboard decoder
interrupt_ack  in  1  PicoBlaze ack pulse; pops head entry
clear  in  1  synchronous flush
interrupt  out  1  to PicoBlaze interrupt input
data_out  out  DATA_W  head entry; feeds PicoBlaze in_port
count  out  clog2(DEPTH)+1  occupancy
overflow  out  1  sticky: a code was dropped while full

Behaviour:
- Reset (async, active-high): pointers=0, count=0, interrupt=0, data_out=0, overflow=0, state=S_EMPTY, gap counter=0.
- Storage: register array; wr_ptr/rd_ptr are clog2(DEPTH) bits and wrap modulo DEPTH.
- data_out is registered and equals the head entry whenever count>0.
  - Push into an empty FIFO at edge t: data_out=key_code and count=1 after edge t.
  - Pop: data_out loads the next entry at the same edge.
  - When empty, data_out holds the last popped value.
- Push: key_valid=1 and (count<DEPTH, or a pop occurs in the same cycle) → write at wr_ptr; wr_ptr+1.
- Full and key_valid without pop: code dropped; overflow←1 (sticky); count unchanged.
- Pop: interrupt_ack=1 and count>0 → rd_ptr+1. interrupt_ack while empty is ignored.
- Simultaneous push and pop: both occur; count unchanged. When empty, only the push occurs.
- count updates at the same edge as the push/pop.
- State machine (interrupt is a registered output):
  - S_EMPTY: interrupt=0. Go to S_PEND when count becomes nonzero (next cycle after the push edge).
  - S_PEND: interrupt=1. On interrupt_ack → S_GAP, load gap counter with IRQ_GAP.
  - S_GAP: interrupt=0. Decrement each cycle. At 0 → S_PEND if count>0, else S_EMPTY. Acks in S_GAP still pop but do not reload the counter.
- Interrupt latency: push at edge t into idle empty FIFO → interrupt=1 after edge t.
- clear=1: pointers=0, count=0, overflow=0, state=S_EMPTY, interrupt=0 at the next edge. clear has priority over a same-cycle push/pop; data_out is unchanged.
- Reset mid-operation: all contents discarded immediately; no partial state survives.

Optional Feature:
- Macro: KEY_DUP_FILTER_EN.
- Defined:
  - A push whose key_code equals the last accepted code is discarded if it arrives within REPEAT_HOLD cycles of that accept.
  - Each accept restarts the hold counter.
  - Discarded duplicates never set overflow.
  - clear and reset invalidate the last-code register.
- Undefined: every key_valid is a push candidate. The hold counter and last-code register are not synthesised.

Decomposition:
- Shared package kbd_pkg:
  - default DATA_W/DEPTH constants;
  - state encoding S_EMPTY/S_PEND/S_GAP;
  - clog2 function.
- One natural sub-module, irq_holdoff_fsm: state machine plus gap counter.
  - Inputs: nonempty, interrupt_ack, clear.
  - Output: interrupt.
- Storage and pointers stay in key_event_fifo.

Test Plan:
- Single key: key_code=0x41 pulse → next cycle interrupt=1, data_out=0x41, count=1. Ack → count=0, interrupt=0, and it stays low after the gap expires.
- Burst: push 0x31,0x32,0x33 back-to-back, then ack once → data_out=0x32, interrupt low exactly IRQ_GAP=4 cycles, then high again. Two more acks drain, with data_out=0x33 before the last ack.
- Overflow: 9 pushes 0x01..0x09 with DEPTH=8 → count=8, overflow=1, head=0x01. 8 acks return 0x01..0x08, never 0x09.
- Full with simultaneous push+ack: push 0x55 with ack while count=8 → count stays 8, overflow stays 0, 0x55 read last.
- clear and reset: clear while count=5 → count=0, interrupt=0, overflow=0. Async reset asserted mid-gap → all outputs zero without a clock edge.
- KEY_DUP_FILTER_EN, REPEAT_HOLD=10: 0x61 at t=0 and t=5 → count=1. 0x61 at t=20 → count=2.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared definitions for the keyboard event path: default sizes, interrupt
// hold-off state encoding and a constant-friendly clog2.
package kbd_pkg;

  localparam int unsigned DefDataW = 8;
  localparam int unsigned DefDepth = 8;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PEND  = 2'd1,
    S_GAP   = 2'd2
  } irq_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(value)) r++;
    return r;
  endfunction

endpackage

// File: rtl/irq_holdoff_fsm.sv
// Interrupt request state machine: raises interrupt while codes are pending and
// holds it low for IRQ_GAP cycles after each acknowledge.
module irq_holdoff_fsm
  import kbd_pkg::*;
#(
  parameter int unsigned IRQ_GAP = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic nonempty,
  input  logic interrupt_ack,
  input  logic clear,
  output logic interrupt
);

  localparam int unsigned GW = clog2(IRQ_GAP + 1);
  localparam logic [GW-1:0] GapLoad = GW'(IRQ_GAP);
  localparam logic [GW-1:0] GapOne  = GW'(1);

  irq_state_e    state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          irq_q, irq_d;

  // nonempty reflects the occupancy after this edge, so the interrupt rises
  // together with the count.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    irq_d   = irq_q;
    if (clear) begin
      state_d = S_EMPTY;
      gap_d   = '0;
      irq_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (nonempty) begin
            state_d = S_PEND;
            irq_d   = 1'b1;
          end
        end
        S_PEND: begin
          if (interrupt_ack) begin
            state_d = S_GAP;
            gap_d   = GapLoad;
            irq_d   = 1'b0;
          end
        end
        S_GAP: begin
          if (gap_q <= GapOne) begin
            gap_d   = '0;
            state_d = nonempty ? S_PEND : S_EMPTY;
            irq_d   = nonempty;
          end else begin
            gap_d = gap_q - GapOne;
          end
        end
        default: begin
          state_d = S_EMPTY;
          gap_d   = '0;
          irq_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_EMPTY;
      gap_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      irq_q   <= irq_d;
    end
  end

  assign interrupt = irq_q;

endmodule

// File: rtl/key_event_fifo.sv
// Key code FIFO between the PS/2 decoder and the PicoBlaze, with interrupt
// hold-off and sticky overflow. Optional KEY_DUP_FILTER_EN drops fast repeats.
module key_event_fifo
  import kbd_pkg::*;
#(
  parameter int unsigned DATA_W      = DefDataW,
  parameter int unsigned DEPTH       = DefDepth,
  parameter int unsigned IRQ_GAP     = 4,
  parameter int unsigned REPEAT_HOLD = 1000000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       key_valid,
  input  logic [DATA_W-1:0]          key_code,
  input  logic                       interrupt_ack,
  input  logic                       clear,
  output logic                       interrupt,
  output logic [DATA_W-1:0]          data_out,
  output logic [clog2(DEPTH):0]      count,
  output logic                       overflow
);

  localparam int unsigned PW = clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [CW-1:0] CntOne = CW'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two and at least 2");
  end
  if (IRQ_GAP < 1 || REPEAT_HOLD < 1) begin : g_bad_timing
    $error("IRQ_GAP and REPEAT_HOLD must be at least 1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ovf_q, ovf_d;
  logic              full, pop, push, drop, dup;

  assign full    = (count_q == DepthC);
  assign rd_next = rd_ptr_q + 1'b1;
  assign pop     = interrupt_ack && (count_q != '0) && !clear;
  assign push    = key_valid && !dup && (!full || pop) && !clear;
  assign drop    = key_valid && !dup && full && !pop && !clear;

`ifdef KEY_DUP_FILTER_EN
  localparam int unsigned HW = clog2(REPEAT_HOLD + 1);
  localparam logic [HW-1:0] HoldMax = HW'(REPEAT_HOLD);

  logic [DATA_W-1:0] last_code_q, last_code_d;
  logic              last_vld_q, last_vld_d;
  logic [HW-1:0]     hold_q, hold_d;

  assign dup = key_valid && last_vld_q && (key_code == last_code_q) && (hold_q < HoldMax);

  // hold_q counts cycles since the last accept and saturates at the window.
  always_comb begin
    last_code_d = last_code_q;
    last_vld_d  = last_vld_q;
    hold_d      = (hold_q < HoldMax) ? hold_q + 1'b1 : hold_q;
    if (clear) begin
      last_vld_d = 1'b0;
    end else if (push) begin
      last_code_d = key_code;
      last_vld_d  = 1'b1;
      hold_d      = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_code_q <= '0;
      last_vld_q  <= 1'b0;
      hold_q      <= '0;
    end else begin
      last_code_q <= last_code_d;
      last_vld_q  <= last_vld_d;
      hold_q      <= hold_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = key_code;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_next;
      if (push && !pop) count_d = count_q + CntOne;
      if (pop && !push) count_d = count_q - CntOne;
      if (drop) ovf_d = 1'b1;
      // Popping the last entry while pushing hands the new code straight to the head.
      if (pop) begin
        if (count_q > CntOne) data_d = mem_q[rd_next];
        else if (push)        data_d = key_code;
      end else if (push && count_q == '0) begin
        data_d = key_code;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
    end
  end

  irq_holdoff_fsm #(
    .IRQ_GAP(IRQ_GAP)
  ) u_irq (
    .clk          (clk),
    .reset        (reset),
    .nonempty     (count_d != '0),
    .interrupt_ack(interrupt_ack),
    .clear        (clear),
    .interrupt    (interrupt)
  );

  assign data_out = data_q;
  assign count    = count_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_key_event_fifo.sv
// Directed bench for key_event_fifo: vector table plus hand-written corner sequences.
module tb_key_event_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       interrupt_ack;
  logic       clear;
  logic       interrupt;
  logic [7:0] data_out;
  logic [3:0] count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_event_fifo #(
    .DATA_W     (8),
    .DEPTH      (8),
    .IRQ_GAP    (4),
    .REPEAT_HOLD(10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .interrupt_ack(interrupt_ack),
    .clear        (clear),
    .interrupt    (interrupt),
    .data_out     (data_out),
    .count        (count),
    .overflow     (overflow)
  );

  typedef struct {
    logic       kv;
    logic [7:0] kc;
    logic       ack;
    logic       clr;
    logic       e_int;
    logic [7:0] e_data;
    logic [3:0] e_cnt;
    logic       e_ovf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic kv, input logic [7:0] kc, input logic ack,
                              input logic clr, input logic ei, input logic [7:0] ed,
                              input logic [3:0] ec, input logic eo);
    vec_t v;
    v.kv = kv; v.kc = kc; v.ack = ack; v.clr = clr;
    v.e_int = ei; v.e_data = ed; v.e_cnt = ec; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic ei, input logic [7:0] ed,
                         input logic [3:0] ec, input logic eo);
    chk({tag, ".interrupt"}, int'(interrupt), int'(ei));
    chk({tag, ".data_out"}, int'(data_out), int'(ed));
    chk({tag, ".count"}, int'(count), int'(ec));
    chk({tag, ".overflow"}, int'(overflow), int'(eo));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic cyc(input logic kv, input logic [7:0] kc, input logic ack, input logic clr);
    key_valid = kv; key_code = kc; interrupt_ack = ack; clear = clr;
    @(posedge clk);
    #1;
    key_valid = 1'b0; interrupt_ack = 1'b0; clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] drain [8];
    reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; interrupt_ack = 1'b0; clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 8'h00, 4'd0, 1'b0);
    reset = 1'b0;

    // Single key, then a three-key burst with gap timing.
    vecs.push_back(mk(1, 8'h41, 0, 0, 1, 8'h41, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h41, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h41, 0, 0));
    vecs.push_back(mk(1, 8'h31, 0, 0, 1, 8'h31, 1, 0));
    vecs.push_back(mk(1, 8'h32, 0, 0, 1, 8'h31, 2, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 8'h31, 3, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h32, 2, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h32, 2, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h32, 2, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h33, 1, 0));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h33, 1, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 1, 8'h33, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h33, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h33, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].kv, vecs[i].kc, vecs[i].ack, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_int, vecs[i].e_data, vecs[i].e_cnt,
              vecs[i].e_ovf);
    end

    // Overflow: ninth code is dropped.
    for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
    chk_all("ovf_full", 1'b1, 8'h01, 4'd8, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_head%0d", i), int'(data_out), i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk_all("ovf_drained", 1'b0, 8'h08, 4'd0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk_all("ovf_clear", 1'b0, 8'h08, 4'd0, 1'b0);
    idle(6);

    // Full FIFO with push and ack together.
    for (int i = 0; i < 8; i++) cyc(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    chk_all("full8", 1'b1, 8'h11, 4'd8, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0);
    chk_all("full_pushpop", 1'b0, 8'h12, 4'd8, 1'b0);
    drain = '{8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h55};
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("full_head%0d", i), int'(data_out), int'(drain[i]));
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk_all("full_drained", 1'b0, 8'h55, 4'd0, 1'b0);
    idle(6);

    // clear beats a same-cycle push and ack.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'hA1 + 8'(i), 1'b0, 1'b0);
    chk_all("clr_pre", 1'b1, 8'hA1, 4'd5, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b1);
    chk_all("clr", 1'b0, 8'hA1, 4'd0, 1'b0);
    idle(1);
    chk_all("clr_after", 1'b0, 8'hA1, 4'd0, 1'b0);

    // Asynchronous reset in the middle of a gap.
    cyc(1'b1, 8'hC1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    idle(1);
    chk_all("gap_pre_reset", 1'b0, 8'hC2, 4'd1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b0, 8'h00, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);
    chk_all("post_reset_idle", 1'b0, 8'h00, 4'd0, 1'b0);
    cyc(1'b1, 8'h77, 1'b0, 1'b0);
    chk_all("post_reset_push", 1'b1, 8'h77, 4'd1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);

    // Repeated code inside and outside the hold window.
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    chk("dup_t0.count", int'(count), 1);
    idle(4);
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
`ifdef KEY_DUP_FILTER_EN
    chk("dup_t5.count", int'(count), 1);
`else
    chk("dup_t5.count", int'(count), 2);
`endif
    idle(14);
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
`ifdef KEY_DUP_FILTER_EN
    chk("dup_t20.count", int'(count), 2);
`else
    chk("dup_t20.count", int'(count), 3);
`endif
    chk("dup_ovf", int'(overflow), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
